// File: rtl/uart_baud_gen.sv
// Fractional baud tick generator: a phase accumulator (NCO) produces the oversample tick,
// and a slot counter derives the mid-bit sample tick and the bit-boundary tick from it.
module uart_baud_gen #(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned OVERSAMPLE = 8,
    parameter int unsigned ACC_W      = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          restart,
    input  logic [2:0]                    baud_sel,
    output logic                          os_tick,
    output logic                          mid_tick,
    output logic                          bit_tick,
    output logic [$clog2(OVERSAMPLE)-1:0] phase
);

    localparam int unsigned PH_W = $clog2(OVERSAMPLE);
    localparam logic [PH_W-1:0] MID_SLOT  = PH_W'(OVERSAMPLE / 2 - 1);
    localparam logic [PH_W-1:0] LAST_SLOT = PH_W'(OVERSAMPLE - 1);

    // Rounded increment: BAUD * OVERSAMPLE * 2^ACC_W / CLK_HZ, done in 64 bits.
    function automatic logic [63:0] calc_inc(input longint unsigned baud);
        logic [63:0] num;
        num = (64'(baud) * 64'(OVERSAMPLE)) << ACC_W;
        return (num + 64'(CLK_HZ / 2)) / 64'(CLK_HZ);
    endfunction

    localparam logic [63:0] INC_TAB [0:7] = '{
        calc_inc(9600),   calc_inc(19200),  calc_inc(38400),  calc_inc(57600),
        calc_inc(115200), calc_inc(230400), calc_inc(460800), calc_inc(921600)
    };

    if (OVERSAMPLE != 8 && OVERSAMPLE != 16) begin : g_bad_os
        $error("uart_baud_gen: OVERSAMPLE must be 8 or 16");
    end

    // Keeping INC below a quarter turn guarantees ticks are never back-to-back.
    for (genvar k = 0; k < 8; k++) begin : g_inc_chk
        if (INC_TAB[k] >= (64'd1 << (ACC_W - 2))) begin : g_bad_inc
            $error("uart_baud_gen: increment too large for ACC_W");
        end
    end

    logic [2:0]       sel_q;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] inc_sel;
    logic [ACC_W:0]   sum;
    logic             carry;

    assign inc_sel = INC_TAB[sel_q][ACC_W-1:0];
    assign sum     = {1'b0, acc} + {1'b0, inc_sel};
    assign carry   = sum[ACC_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q    <= 3'd0;
            acc      <= '0;
            phase    <= '0;
            os_tick  <= 1'b0;
            mid_tick <= 1'b0;
            bit_tick <= 1'b0;
        end else begin
            os_tick  <= 1'b0;
            mid_tick <= 1'b0;
            bit_tick <= 1'b0;
            if (restart) begin
                acc   <= '0;
                phase <= '0;
            end else if (baud_sel != sel_q) begin
                // New rate starts from a clean phase; it takes effect next cycle.
                sel_q <= baud_sel;
                acc   <= '0;
                phase <= '0;
            end else if (en) begin
                acc      <= sum[ACC_W-1:0];
                os_tick  <= carry;
                mid_tick <= carry && (phase == MID_SLOT);
                bit_tick <= carry && (phase == LAST_SLOT);
                if (carry) begin
                    phase <= phase + 1'b1;
                end
            end
        end
    end

endmodule
